// File: rtl/bcm_plane_sequencer_pkg.sv
// bcm_plane_sequencer_pkg: shared types and parameter checks for the BCM plane sequencer.
// The BLANK state is only reachable when BCM_DEAD_TIME_EN is defined.
package bcm_plane_sequencer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_LOAD  = 3'd1,
        ST_LATCH = 3'd2,
        ST_SHOW  = 3'd3,
        ST_BLANK = 3'd4
    } state_e;

    // The interval counter must hold base_value << (PLANES-1) without overflow.
    function automatic bit counter_width_ok(input int cw, input int bw, input int planes);
        return cw >= (bw + planes - 1);
    endfunction

endpackage

// File: rtl/bcm_plane_sequencer_plane_countdown.sv
// bcm_plane_sequencer_plane_countdown: loadable down-counter that stops at zero.
// Used for both the OE on-time and the post-plane blanking interval.
module bcm_plane_sequencer_plane_countdown #(
    parameter int WIDTH = 16
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    output logic [WIDTH-1:0] count_o,
    output logic             nonzero_o
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // load takes priority; otherwise count down and hold at zero
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (count_q != '0) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // counter register
    always_ff @(posedge clk_in) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o   = count_q;
    assign nonzero_o = (count_q != '0);

endmodule

// File: rtl/bcm_plane_sequencer.sv
// bcm_plane_sequencer: BCM bit-plane sequencer for an LED panel.
// For each row it requests plane data from the row shifter, pulses latch, then
// holds OE for base_value << plane cycles. Owns row address, latch and OE.
// Optional macro BCM_DEAD_TIME_EN: inserts a BLANK interval of DEAD_CYCLES
// after every plane; when undefined the next plane starts straight after OE.
module bcm_plane_sequencer
    import bcm_plane_sequencer_pkg::*;
#(
    parameter int PLANES        = 8,
    parameter int ROWS          = 16,
    parameter int BASE_WIDTH    = 8,
    parameter int COUNTER_WIDTH = 16,
    parameter int DEAD_CYCLES   = 2,
    localparam int PLANE_W      = (PLANES > 1) ? $clog2(PLANES) : 1,
    localparam int ROW_W        = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  enable_i,
    input  logic [BASE_WIDTH-1:0] base_value_i,
    output logic                  load_req_o,
    input  logic                  load_done_i,
    output logic [PLANE_W-1:0]    plane_o,
    output logic [ROW_W-1:0]      row_o,
    output logic                  latch_o,
    output logic                  oe_o,
    output logic                  row_done_o,
    output logic                  busy_o
);

`ifdef BCM_DEAD_TIME_EN
    localparam int MIN_DEAD = 1;
    localparam logic [COUNTER_WIDTH-1:0] DEAD_LOAD = COUNTER_WIDTH'(DEAD_CYCLES);
`else
    localparam int MIN_DEAD = 0;
`endif

    localparam logic [PLANE_W-1:0] LAST_PLANE = PLANE_W'(PLANES - 1);
    localparam logic [ROW_W-1:0]   LAST_ROW   = ROW_W'(ROWS - 1);

    if (!counter_width_ok(COUNTER_WIDTH, BASE_WIDTH, PLANES) || (DEAD_CYCLES < MIN_DEAD)) begin : g_param_err
        $error("bcm_plane_sequencer: COUNTER_WIDTH too small or DEAD_CYCLES out of range");
    end

    state_e                 state_q, state_d;
    logic [PLANE_W-1:0]     plane_q, plane_d;
    logic [ROW_W-1:0]       row_q, row_d;
    logic [BASE_WIDTH-1:0]  base_q, base_d;

    logic                     cnt_load;
    logic [COUNTER_WIDTH-1:0] cnt_load_val;
    logic [COUNTER_WIDTH-1:0] cnt_count;
    logic                     cnt_nonzero;
    logic                     cnt_expiring;
    logic [COUNTER_WIDTH-1:0] show_len;
    logic                     end_show;
    logic                     end_plane;
    logic                     row_done;

    bcm_plane_sequencer_plane_countdown #(
        .WIDTH (COUNTER_WIDTH)
    ) u_countdown (
        .clk_in     (clk_in),
        .reset      (reset),
        .load_i     (cnt_load),
        .load_val_i (cnt_load_val),
        .count_o    (cnt_count),
        .nonzero_o  (cnt_nonzero)
    );

    // on-time of the current plane; base_q is zero-extended before shifting
    assign show_len     = COUNTER_WIDTH'(base_q) << plane_q;
    // last cycle of the running interval
    assign cnt_expiring = cnt_nonzero && (cnt_count == COUNTER_WIDTH'(1));

    // state and datapath registers
    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q <= ST_IDLE;
            plane_q <= '0;
            row_q   <= '0;
            base_q  <= '0;
        end else begin
            state_q <= state_d;
            plane_q <= plane_d;
            row_q   <= row_d;
            base_q  <= base_d;
        end
    end

    // next-state, interval loading and end-of-plane / end-of-row decisions
    always_comb begin
        state_d      = state_q;
        plane_d      = plane_q;
        row_d        = row_q;
        base_d       = base_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        end_show     = 1'b0;
        end_plane    = 1'b0;
        row_done     = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (enable_i) begin
                    base_d  = base_value_i;
                    plane_d = '0;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (load_done_i) begin
                    state_d = ST_LATCH;
                end
            end
            ST_LATCH: begin
                if (show_len != '0) begin
                    cnt_load     = 1'b1;
                    cnt_load_val = show_len;
                    state_d      = ST_SHOW;
                end else begin
                    end_show = 1'b1;
                end
            end
            ST_SHOW: begin
                if (cnt_expiring) begin
                    end_show = 1'b1;
                end
            end
`ifdef BCM_DEAD_TIME_EN
            ST_BLANK: begin
                if (cnt_expiring) begin
                    end_plane = 1'b1;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef BCM_DEAD_TIME_EN
        if (end_show) begin
            cnt_load     = 1'b1;
            cnt_load_val = DEAD_LOAD;
            state_d      = ST_BLANK;
        end
`else
        end_plane = end_show;
`endif

        if (end_plane) begin
            if (plane_q != LAST_PLANE) begin
                plane_d = plane_q + PLANE_W'(1);
                state_d = ST_LOAD;
            end else begin
                row_done = 1'b1;
                row_d    = (row_q == LAST_ROW) ? '0 : row_q + ROW_W'(1);
                plane_d  = '0;
                if (enable_i) begin
                    base_d  = base_value_i;
                    state_d = ST_LOAD;
                end else begin
                    state_d = ST_IDLE;
                end
            end
        end
    end

    assign load_req_o = (state_q == ST_LOAD);
    assign latch_o    = (state_q == ST_LATCH);
    assign oe_o       = (state_q == ST_SHOW);
    assign busy_o     = (state_q != ST_IDLE);
    assign row_done_o = row_done;
    assign plane_o    = plane_q;
    assign row_o      = row_q;

endmodule

// File: tb/tb_bcm_plane_sequencer.sv
// tb_bcm_plane_sequencer: self-checking bench for bcm_plane_sequencer (PLANES=4, ROWS=16).
// Expected per-plane records (plane, row, OE length, OE-to-next-load gap) are
// queued when a row is started and compared against records built by a monitor.
module tb_bcm_plane_sequencer;

    localparam int PLANES = 4;
    localparam int ROWS   = 16;
    localparam int BW     = 8;
    localparam int CW     = 16;
    localparam int DEAD   = 2;
`ifdef BCM_DEAD_TIME_EN
    localparam int EXP_GAP = DEAD;
`else
    localparam int EXP_GAP = 0;
`endif

    typedef struct packed {
        int plane;
        int row;
        int len;
        int gap;
    } rec_t;

    logic          clk_in     = 1'b0;
    logic          reset      = 1'b1;
    logic          enable     = 1'b0;
    logic [BW-1:0] base_value = '0;
    logic          load_done  = 1'b0;
    logic          load_req, latch, oe, row_done, busy;
    logic [1:0]    plane;
    logic [3:0]    row;

    int   n_checks = 0;
    int   n_fail   = 0;
    rec_t exp_q[$];
    rec_t obs_q[$];
    int   obs_rd    = 0;
    int   model_row = 0;

    int   cyc = 0, rd_cnt = 0, oe_cycles = 0, latch_oe_cnt = 0, lr_oe_cnt = 0;
    rec_t cur;
    bit   active = 1'b0, prev_lr = 1'b0;
    int   last_oe_cyc = 0;

    bcm_plane_sequencer #(
        .PLANES        (PLANES),
        .ROWS          (ROWS),
        .BASE_WIDTH    (BW),
        .COUNTER_WIDTH (CW),
        .DEAD_CYCLES   (DEAD)
    ) dut (
        .clk_in       (clk_in),
        .reset        (reset),
        .enable_i     (enable),
        .base_value_i (base_value),
        .load_req_o   (load_req),
        .load_done_i  (load_done),
        .plane_o      (plane),
        .row_o        (row),
        .latch_o      (latch),
        .oe_o         (oe),
        .row_done_o   (row_done),
        .busy_o       (busy)
    );

    always #5 clk_in = ~clk_in;

    // row shifter model: load_done pulse 3 cycles after load_req rises
    initial begin
        forever begin
            @(negedge clk_in);
            if (load_req && !reset) begin
                repeat (2) @(negedge clk_in);
                load_done = 1'b1;
                @(negedge clk_in);
                load_done = 1'b0;
            end
        end
    end

    // monitor: builds one record per latched plane
    initial begin
        forever begin
            @(negedge clk_in);
            #1;
            cyc = cyc + 1;
            if (reset) begin
                active = 1'b0;
            end else begin
                if (active && ((load_req && !prev_lr) || !busy)) begin
                    cur.gap = (cur.len != 0 && load_req) ? (cyc - last_oe_cyc - 1) : -1;
                    obs_q.push_back(cur);
                    active = 1'b0;
                end
                if (latch) begin
                    cur.plane = int'(plane);
                    cur.row   = int'(row);
                    cur.len   = 0;
                    active    = 1'b1;
                end
                if (oe) begin
                    cur.len     = cur.len + 1;
                    last_oe_cyc = cyc;
                    oe_cycles   = oe_cycles + 1;
                end
                if (row_done) rd_cnt = rd_cnt + 1;
                if (latch && oe) latch_oe_cnt = latch_oe_cnt + 1;
                if (load_req && oe) lr_oe_cnt = lr_oe_cnt + 1;
            end
            prev_lr = load_req;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, required completion before it");
        $fatal(1);
    end

    task automatic push_row(input int base, input bit last_row);
        rec_t r;
        for (int p = 0; p < PLANES; p++) begin
            r.plane = p;
            r.row   = model_row;
            r.len   = base << p;
            r.gap   = (r.len != 0 && !(last_row && p == PLANES - 1)) ? EXP_GAP : -1;
            exp_q.push_back(r);
        end
        model_row = (model_row + 1) % ROWS;
    endtask

    task automatic wait_idle(input int max_cyc, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            @(negedge clk_in);
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_reset();
        logic [3:0] got[7];
        string      nm[7];
        reset  = 1'b1;
        enable = 1'b0;
        repeat (3) @(negedge clk_in);
        nm  = '{"oe", "busy", "latch", "load_req", "row_done", "row", "plane"};
        got = '{4'(oe), 4'(busy), 4'(latch), 4'(load_req), 4'(row_done), row, 4'(plane)};
        for (int i = 0; i < 7; i++) begin
            n_checks++;
            if (got[i] !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_%s: got %0d required 0", nm[i], got[i]);
            end
        end
        reset = 1'b0;
        repeat (2) @(negedge clk_in);
    endtask

    task automatic test_basic();
        bit ok;
        int rd0;
        rd0 = rd_cnt;
        @(negedge clk_in);
        base_value = 8'd2;
        enable     = 1'b1;
        push_row(2, 1'b1);
        @(negedge clk_in);
        enable = 1'b0;
        n_checks++;
        if (load_req !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_start_latency: load_req=%b busy=%b required 1 1", load_req, busy);
        end
        ok = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk_in);
            #2;
            if (load_done) begin
                ok = 1'b1;
                break;
            end
        end
        @(negedge clk_in);
        n_checks++;
        if (!ok || latch !== 1'b1 || oe !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_latch_latency: seen_done=%b latch=%b oe=%b required 1 1 0", ok, latch, oe);
        end
        @(negedge clk_in);
        n_checks++;
        if (oe !== 1'b1 || latch !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_oe_latency: oe=%b latch=%b required 1 0", oe, latch);
        end
        wait_idle(400, ok);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL basic_timeout: busy still %b, required 0", busy);
        end
        n_checks++;
        if (rd_cnt - rd0 !== 1 || row !== 4'(model_row)) begin
            n_fail++;
            $display("FAIL basic_row_end: row_done count %0d row %0d, required 1 and %0d", rd_cnt - rd0, row, model_row);
        end
        while (exp_q.size() != 0) begin
            rec_t e, o;
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) begin
                n_fail++;
                $display("FAIL basic_plane: missing record, required p%0d r%0d len %0d gap %0d", e.plane, e.row, e.len, e.gap);
            end else begin
                o = obs_q[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL basic_plane: got p%0d r%0d len %0d gap %0d, required p%0d r%0d len %0d gap %0d",
                             o.plane, o.row, o.len, o.gap, e.plane, e.row, e.len, e.gap);
                end
            end
        end
        n_checks++;
        if (obs_rd != obs_q.size()) begin
            n_fail++;
            $display("FAIL basic_extra: %0d unexpected plane records, required 0", obs_q.size() - obs_rd);
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_base_change();
        bit ok;
        @(negedge clk_in);
        base_value = 8'd3;
        enable     = 1'b1;
        push_row(3, 1'b0);
        push_row(5, 1'b1);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk_in);
            if (plane == 2'd1 && oe) begin
                ok = 1'b1;
                break;
            end
        end
        base_value = 8'd5;
        for (int i = 0; i < 300; i++) begin
            if (row_done) break;
            @(negedge clk_in);
        end
        @(negedge clk_in);
        enable = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL base_change_plane1_timeout: plane %0d oe %b, required plane 1 with oe", plane, oe);
        end
        wait_idle(600, ok);
        n_checks++;
        if (!ok || row !== 4'(model_row)) begin
            n_fail++;
            $display("FAIL base_change_end: idle=%b row %0d, required 1 and %0d", ok, row, model_row);
        end
        while (exp_q.size() != 0) begin
            rec_t e, o;
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) begin
                n_fail++;
                $display("FAIL base_change_plane: missing record, required p%0d r%0d len %0d gap %0d", e.plane, e.row, e.len, e.gap);
            end else begin
                o = obs_q[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL base_change_plane: got p%0d r%0d len %0d gap %0d, required p%0d r%0d len %0d gap %0d",
                             o.plane, o.row, o.len, o.gap, e.plane, e.row, e.len, e.gap);
                end
            end
        end
        n_checks++;
        if (obs_rd != obs_q.size()) begin
            n_fail++;
            $display("FAIL base_change_extra: %0d unexpected plane records, required 0", obs_q.size() - obs_rd);
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_zero_base();
        bit ok;
        int rd0, oe0;
        rd0 = rd_cnt;
        oe0 = oe_cycles;
        @(negedge clk_in);
        base_value = 8'd0;
        enable     = 1'b1;
        push_row(0, 1'b1);
        @(negedge clk_in);
        enable = 1'b0;
        wait_idle(200, ok);
        n_checks++;
        if (!ok || rd_cnt - rd0 !== 1 || oe_cycles - oe0 !== 0) begin
            n_fail++;
            $display("FAIL zero_base_row: idle=%b row_done %0d oe_cycles %0d, required 1 1 0", ok, rd_cnt - rd0, oe_cycles - oe0);
        end
        while (exp_q.size() != 0) begin
            rec_t e, o;
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) begin
                n_fail++;
                $display("FAIL zero_base_plane: missing record, required p%0d r%0d len %0d gap %0d", e.plane, e.row, e.len, e.gap);
            end else begin
                o = obs_q[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL zero_base_plane: got p%0d r%0d len %0d gap %0d, required p%0d r%0d len %0d gap %0d",
                             o.plane, o.row, o.len, o.gap, e.plane, e.row, e.len, e.gap);
                end
            end
        end
        n_checks++;
        if (obs_rd != obs_q.size()) begin
            n_fail++;
            $display("FAIL zero_base_extra: %0d unexpected plane records, required 0", obs_q.size() - obs_rd);
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_row_wrap();
        bit ok;
        int rd0, start_row, seen;
        rd0       = rd_cnt;
        start_row = model_row;
        seen      = 0;
        @(negedge clk_in);
        base_value = 8'd1;
        enable     = 1'b1;
        for (int r = 0; r < ROWS; r++) push_row(1, r == ROWS - 1);
        for (int i = 0; i < 4000 && seen < ROWS - 1; i++) begin
            @(negedge clk_in);
            if (row_done) seen++;
        end
        @(negedge clk_in);
        enable = 1'b0;
        wait_idle(1000, ok);
        n_checks++;
        if (!ok || rd_cnt - rd0 !== ROWS || row !== 4'(start_row)) begin
            n_fail++;
            $display("FAIL row_wrap_count: idle=%b row_done %0d row %0d, required 1 %0d %0d", ok, rd_cnt - rd0, row, ROWS, start_row);
        end
        while (exp_q.size() != 0) begin
            rec_t e, o;
            e = exp_q.pop_front();
            n_checks++;
            if (obs_rd >= obs_q.size()) begin
                n_fail++;
                $display("FAIL row_wrap_plane: missing record, required p%0d r%0d len %0d gap %0d", e.plane, e.row, e.len, e.gap);
            end else begin
                o = obs_q[obs_rd];
                obs_rd++;
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL row_wrap_plane: got p%0d r%0d len %0d gap %0d, required p%0d r%0d len %0d gap %0d",
                             o.plane, o.row, o.len, o.gap, e.plane, e.row, e.len, e.gap);
                end
            end
        end
        n_checks++;
        if (obs_rd != obs_q.size()) begin
            n_fail++;
            $display("FAIL row_wrap_extra: %0d unexpected plane records, required 0", obs_q.size() - obs_rd);
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_enable_drop();
        bit ok;
        int rd0, rd_at, fall_at;
        rd0     = rd_cnt;
        rd_at   = -10;
        fall_at = -1;
        @(negedge clk_in);
        base_value = 8'd2;
        enable     = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_in);
            if (plane == 2'd2 && oe) begin
                ok = 1'b1;
                break;
            end
        end
        enable = 1'b0;
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL enable_drop_plane2_timeout: plane %0d oe %b, required plane 2 with oe", plane, oe);
        end
        for (int i = 0; i < 300; i++) begin
            @(negedge clk_in);
            if (row_done) rd_at = i;
            if (!busy) begin
                fall_at = i;
                break;
            end
        end
        model_row = (model_row + 1) % ROWS;
        repeat (2) @(negedge clk_in);
        n_checks++;
        if (fall_at != rd_at + 1) begin
            n_fail++;
            $display("FAIL enable_drop_busy_fall: busy fell at %0d, required %0d (cycle after row_done)", fall_at, rd_at + 1);
        end
        n_checks++;
        if (rd_cnt - rd0 !== 1 || row !== 4'(model_row) || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL enable_drop_row_end: row_done %0d row %0d busy %b, required 1 %0d 0", rd_cnt - rd0, row, busy, model_row);
        end
        obs_rd = obs_q.size();
    endtask

    task automatic test_reset_mid();
        bit         ok;
        logic [3:0] got[6];
        string      nm[6];
        @(negedge clk_in);
        base_value = 8'd4;
        enable     = 1'b1;
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_in);
            if (oe) begin
                ok = 1'b1;
                break;
            end
        end
        reset  = 1'b1;
        enable = 1'b0;
        @(negedge clk_in);
        n_checks++;
        if (!ok) begin
            n_fail++;
            $display("FAIL reset_mid_show_timeout: oe never rose, required oe high before reset");
        end
        nm  = '{"oe", "busy", "row", "plane", "latch", "load_req"};
        got = '{4'(oe), 4'(busy), row, 4'(plane), 4'(latch), 4'(load_req)};
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (got[i] !== 4'd0) begin
                n_fail++;
                $display("FAIL reset_mid_%s: got %0d required 0", nm[i], got[i]);
            end
        end
        reset     = 1'b0;
        model_row = 0;
        repeat (3) @(negedge clk_in);
        obs_rd = obs_q.size();
    endtask

    task automatic test_invariants();
        n_checks++;
        if (latch_oe_cnt !== 0) begin
            n_fail++;
            $display("FAIL latch_oe_overlap: %0d cycles with latch and oe, required 0", latch_oe_cnt);
        end
        n_checks++;
        if (lr_oe_cnt !== 0) begin
            n_fail++;
            $display("FAIL load_req_in_show: %0d cycles with load_req and oe, required 0", lr_oe_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_base_change();
        test_zero_base();
        test_row_wrap();
        test_enable_drop();
        test_reset_mid();
        test_invariants();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/bcm_plane_sequencer.md
# bcm_plane_sequencer

Initiator side of the display's timed-interval scheme: sequences binary-code-modulation (BCM) bit planes for each LED-panel row by requesting plane data from the row shifter, pulsing the panel latch, and holding output-enable for a plane-weighted interval from an internal countdown. It sits between the frame-buffer/row-shifter path and the panel pins, owning row address, latch and OE.

## Interface
- PLANES, 8: bit planes per row; plane p is weighted 2^p.
- ROWS, 16: row addresses; row counter wraps ROWS-1 -> 0.
- BASE_WIDTH, 8: width of base_value.
- COUNTER_WIDTH, 16: interval counter width; must be >= BASE_WIDTH+PLANES-1.
- DEAD_CYCLES, 2: blanking cycles after each plane (only with BCM_DEAD_TIME_EN).
- clk_in  input  1  clock.
- reset  input  1  synchronous, active-high.
- enable  input  1  permits starting a new row.
- base_value  input  BASE_WIDTH  on-time of plane 0 in clk_in cycles.
- load_req  output  1  request to row shifter to shift plane `plane` of row `row`.
- load_done  input  1  one-cycle pulse from shifter: data shifted.
- plane  output  clog2(PLANES)  current plane index.
- row  output  clog2(ROWS)  current row address (driven to panel).
- latch  output  1  one-cycle panel latch pulse.
- oe  output  1  active-high output enable (LEDs lit).
- row_done  output  1  one-cycle pulse after last plane of a row.
- busy  output  1  high whenever state != IDLE.

## Operation
- States: IDLE, LOAD, LATCH, SHOW, BLANK.
- IDLE: if enable, capture base_value into base_q, plane<=0, -> LOAD. base_value changes mid-row are ignored until next row.
- LOAD: load_req=1; on load_done -> LATCH. load_done seen outside LOAD is ignored.
- LATCH: latch=1 for exactly one cycle; counter <= base_q << plane (zero-extended to COUNTER_WIDTH); -> SHOW, or directly to BLANK/next if interval is 0.
- SHOW: oe=1; counter decrements; when counter==1 -> BLANK (oe high exactly base_q<<plane cycles).
- BLANK: oe=0 for DEAD_CYCLES cycles, then: if plane<PLANES-1, plane+1 -> LOAD; else row_done pulse, row+1 (wrap), plane<=0, -> LOAD if enable (recapturing base_value) else IDLE.
- enable deasserted mid-row: current row completes; no new row starts.
- base_value==0: every plane latched, oe never asserted.
- latch and oe never high in the same cycle; load_req never high during SHOW.
- Reset values: state IDLE, plane 0, row 0, counter 0, all outputs 0. Reset mid-operation aborts immediately; oe drops the next edge.

## Timing
- IDLE->load_req: 1 cycle after enable sampled high.
- load_done -> latch: latch high the cycle after load_done.
- latch -> oe: oe high the cycle after latch, for base_q<<plane cycles.
- Plane period = load wait + 1 (latch) + base_q<<plane + DEAD_CYCLES.
- row_done coincides with row increment edge; row value valid from next cycle.

## Configuration
- BCM_DEAD_TIME_EN defined: BLANK lasts DEAD_CYCLES cycles (DEAD_CYCLES >= 1).
- Undefined: BLANK state removed; SHOW expiry proceeds directly to next-plane/row-end decision in the same transition (zero dead time); DEAD_CYCLES ignored.

## Structure
- Shared package: state enum (IDLE/LOAD/LATCH/SHOW/BLANK), width check constant COUNTER_WIDTH >= BASE_WIDTH+PLANES-1.
- One sub-module: plane_countdown (load value on strobe, decrement to zero, expose nonzero flag), used for SHOW and BLANK intervals.

## Test plan
- PLANES=4, base_value=2, load_done 3 cycles after each load_req -> oe pulses of 2,4,8,16 cycles, one latch before each, row_done once, row 0->1.
- base_value changed 3->5 during plane 1 -> remaining planes use 3; next row uses 5.
- base_value=0 -> four latch pulses, oe never high, row_done asserted.
- ROWS=16, run 16 rows -> row wraps 15->0, row_done count 16.
- enable dropped during plane 2 -> row finishes, busy falls after BLANK, state IDLE; reset asserted during SHOW -> oe/busy/row/plane 0 next cycle.
- With and without BCM_DEAD_TIME_EN (DEAD_CYCLES=2) -> gap between oe fall and next load_req is 2 cycles vs 0 cycles.
